// File: rtl/rc4_ct_decrypt_reader_if.sv
// Bundles the ciphertext memory read port, keystream input, plaintext output and run control
// of the RC4 ciphertext reader; master is the reader, slave is its environment.
interface rc4_ct_decrypt_reader_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              ks_valid;
  logic              ks_ready;
  logic [DATA_W-1:0] ks_data;
  logic              pt_valid;
  logic              pt_ready;
  logic [DATA_W-1:0] pt_data;
  logic [ADDR_W-1:0] pt_index;

  modport master (
    input  start, mem_dout, ks_valid, ks_data, pt_ready,
    output busy, done, mem_rd_en, mem_addr, ks_ready, pt_valid, pt_data, pt_index
  );

  modport slave (
    output start, mem_dout, ks_valid, ks_data, pt_ready,
    input  busy, done, mem_rd_en, mem_addr, ks_ready, pt_valid, pt_data, pt_index
  );
endinterface

// File: rtl/rc4_ct_decrypt_reader.sv
// Walks the ciphertext memory in index order, XORs each entry with one keystream nibble and
// presents the recovered plaintext; 4 cycles per nibble minimum, stalls in KS/OUT on handshakes.
module rc4_ct_decrypt_reader #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic                     clk,
  input logic                     reset,
  rc4_ct_decrypt_reader_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, KS, OUT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [DATA_W-1:0] ct_reg, ct_nxt;
  logic [DATA_W-1:0] pt_reg, pt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      ct_reg <= '0;
      pt_reg <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      ct_reg <= ct_nxt;
      pt_reg <= pt_nxt;
    end
  end

  // mem_dout is only sampled in WAIT so undefined read data never reaches an output.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ct_nxt    = ct_reg;
    pt_nxt    = pt_reg;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = READ;
          idx_nxt   = '0;
        end
      end
      READ: state_nxt = WAIT;
      WAIT: begin
        ct_nxt    = bus.mem_dout;
        state_nxt = KS;
      end
      KS: begin
        if (bus.ks_valid) begin
          pt_nxt    = ct_reg ^ bus.ks_data;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (bus.pt_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = READ;
          end
        end
      end
      DONE: begin
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en = (state == READ);
    bus.ks_ready  = (state == KS);
    bus.pt_valid  = (state == OUT);
    bus.done      = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.mem_addr  = idx;
    bus.pt_index  = idx;
    bus.pt_data   = pt_reg;
  end
endmodule

// File: tb/tb_rc4_ct_decrypt_reader.sv
// Scoreboard bench for rc4_ct_decrypt_reader: memory and keystream models, stalls, abort, restart.
module tb_rc4_ct_decrypt_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rc4_ct_decrypt_reader_if #(.DATA_W(4), .ADDR_W(4)) bus ();

  rc4_ct_decrypt_reader #(.DATA_W(4), .DEPTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] idx;
    logic [3:0] dat;
  } pt_exp_t;

  logic [3:0] mem     [16];
  logic [3:0] ks_tab  [16];
  logic [3:0] exp_tab [16];
  pt_exp_t    exp_q[$];
  int total = 0;
  int bad   = 0;

  // Memory read port: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_dout <= mem[bus.mem_addr];
    else               bus.mem_dout <= 4'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {bus.mem_rd_en, bus.ks_ready, bus.pt_valid, bus.done, bus.busy,
            bus.mem_addr, bus.pt_index, bus.pt_data};
  endfunction

  task automatic run_one(input string tag, input int stall_pt, input int stall_ks,
                         input int start_at, input int abort_at, input bit check_timing);
    int      ks_ptr = 0;
    int      first_pt = -1;
    int      done_cyc = -1;
    int      pt_hold = 0;
    int      ks_hold = 0;
    bit      start_done = 0;
    pt_exp_t e;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), exp_tab[i]});
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
    bus.start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (abort_at >= 0 && bus.pt_valid && int'(bus.pt_index) == abort_at) begin
        reset = 1'b1;
        #1;
        chk({tag, "_abort_outs"}, 32'(all_outs()), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk({tag, "_abort_nodone"}, 32'({bus.done, bus.busy}), 0);
        end
        exp_q.delete();
        return;
      end
      if (bus.done) begin
        done_cyc = cyc;
        chk({tag, "_done_busy"}, 32'(bus.busy), 1);
        break;
      end
      if (bus.ks_ready) begin
        if (int'(bus.pt_index) == stall_ks && ks_hold < 2) begin
          bus.ks_valid = 1'b0;
          bus.ks_data  = 4'($urandom);
          if (ks_hold > 0) chk({tag, "_ks_hold_pt"}, 32'(bus.pt_valid), 0);
          ks_hold++;
        end else begin
          bus.ks_valid = 1'b1;
          bus.ks_data  = ks_tab[ks_ptr];
          ks_ptr++;
        end
      end else begin
        bus.ks_valid = 1'($urandom_range(0, 1));
        bus.ks_data  = 4'($urandom);
      end
      if (bus.pt_valid) begin
        if (first_pt < 0) first_pt = cyc;
        if (exp_q.size() == 0) begin
          chk({tag, "_pt_extra"}, 32'(bus.pt_index), 32'hFF);
          bus.pt_ready = 1'b1;
        end else if (int'(bus.pt_index) == stall_pt && pt_hold < 3) begin
          bus.pt_ready = 1'b0;
          pt_hold++;
          chk({tag, "_stall_idx"}, 32'(bus.pt_index), 32'(exp_q[0].idx));
          chk({tag, "_stall_dat"}, 32'(bus.pt_data), 32'(exp_q[0].dat));
        end else begin
          bus.pt_ready = 1'b1;
          e = exp_q.pop_front();
          chk({tag, "_pt_idx"}, 32'(bus.pt_index), 32'(e.idx));
          chk({tag, "_pt_dat"}, 32'(bus.pt_data), 32'(e.dat));
        end
      end else begin
        bus.pt_ready = 1'($urandom_range(0, 1));
      end
      if (start_at >= 0 && !start_done && int'(bus.pt_index) == start_at) begin
        bus.start  = 1'b1;
        start_done = 1;
      end
    end
    chk({tag, "_done_seen"}, 32'(done_cyc > 0), 1);
    chk({tag, "_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_ks_count"}, 32'(ks_ptr), 16);
    if (stall_ks >= 0) chk({tag, "_ks_stalled"}, 32'(ks_hold), 2);
    if (stall_pt >= 0) chk({tag, "_pt_stalled"}, 32'(pt_hold), 3);
    if (check_timing) begin
      chk({tag, "_first_pt"}, 32'(first_pt), 4);
      chk({tag, "_done_cyc"}, 32'(done_cyc), 65);
    end
  endtask

  initial begin
    logic [63:0] ptxt;
    ptxt = 64'h7EB6_0F1D_92A5_C348;
    bus.start = 1'b0; bus.ks_valid = 1'b0; bus.ks_data = '0; bus.pt_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; ks_tab[i] = '0; exp_tab[i] = '0; end
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(all_outs()), 0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin mem[i] = 4'(i); ks_tab[i] = 4'h0; exp_tab[i] = 4'(i); end
    run_one("t1_ks0", -1, -1, -1, -1, 1);

    for (int i = 0; i < 16; i++) begin ks_tab[i] = 4'hF; exp_tab[i] = ~4'(i); end
    run_one("t2_ksF", -1, -1, -1, -1, 1);

    for (int i = 0; i < 16; i++) begin
      exp_tab[i] = ptxt[63 - 4*i -: 4];
      ks_tab[i]  = 4'($urandom);
      mem[i]     = exp_tab[i] ^ ks_tab[i];
    end
    run_one("t2_rt", -1, -1, -1, -1, 1);
    run_one("t3_ptstall", 5, -1, -1, -1, 0);
    run_one("t4_ksstall", -1, 3, -1, -1, 0);
    run_one("t5_start", -1, -1, 8, -1, 1);
    run_one("t5_abort", -1, -1, -1, 5, 0);

    for (int i = 0; i < 16; i++) begin mem[i] = 4'(i); ks_tab[i] = 4'h0; exp_tab[i] = 4'(i); end
    run_one("t5_restart", -1, -1, -1, -1, 1);
    run_one("t6_b2b", -1, -1, -1, -1, 1);
    @(negedge clk);
    chk("final_idle", 32'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
